// File: rtl/metropolis_sequencer.sv
// Step controller for the metropolis replica bank: per sweep walks every slot through
// opt -> exp init -> exp iterations -> decision -> exchange, and runs distance_shift passes.
module metropolis_sequencer #(
  parameter int unsigned BASE_NUM  = 4,
  parameter int unsigned BASE_LOG  = 2,
  parameter int unsigned EXP_ORDER = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         n_steps,
  input  logic                shift_req,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic [BASE_LOG-1:0] base_id,
  output logic                opt_run,
  output logic                exp_init,
  output logic                exp_run,
  output logic [16:0]         exp_recip,
  output logic                exp_fin,
  output logic                ex_run,
  output logic                ex_odd,
  output logic                distance_shift,
  output logic [31:0]         step_cnt
);

  localparam int unsigned ITER_W = 5;
  localparam logic [ITER_W-1:0]   ITER_LAST = ITER_W'(EXP_ORDER - 1);
  localparam logic [ITER_W-1:0]   K_TOP     = ITER_W'(EXP_ORDER);
  localparam logic [BASE_LOG-1:0] BASE_LAST = BASE_LOG'(BASE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPT,
    S_INIT,
    S_EXP,
    S_FIN,
    S_EXCH,
    S_SHIFT
  } state_t;

  state_t            state;
  logic [ITER_W-1:0] iter;
  logic [31:0]       n_lat;

  // round(65536/k) for the Taylor series terms; k=1 needs the 17th bit
  function automatic logic [16:0] recip_rom(input logic [ITER_W-1:0] k);
    logic [16:0] r;
    case (k)
      5'd1:    r = 17'd65536;
      5'd2:    r = 17'd32768;
      5'd3:    r = 17'd21845;
      5'd4:    r = 17'd16384;
      5'd5:    r = 17'd13107;
      5'd6:    r = 17'd10923;
      5'd7:    r = 17'd9362;
      5'd8:    r = 17'd8192;
      5'd9:    r = 17'd7282;
      5'd10:   r = 17'd6554;
      5'd11:   r = 17'd5958;
      5'd12:   r = 17'd5461;
      5'd13:   r = 17'd5041;
      5'd14:   r = 17'd4681;
      5'd15:   r = 17'd4369;
      5'd16:   r = 17'd4096;
      default: r = 17'd0;
    endcase
    return r;
  endfunction

  // Strobes are set on entry to their state, so each one is high exactly while the FSM sits there
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      iter           <= '0;
      n_lat          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      base_id        <= '0;
      opt_run        <= 1'b0;
      exp_init       <= 1'b0;
      exp_run        <= 1'b0;
      exp_recip      <= '0;
      exp_fin        <= 1'b0;
      ex_run         <= 1'b0;
      ex_odd         <= 1'b0;
      distance_shift <= 1'b0;
      step_cnt       <= '0;
    end else begin
      done           <= 1'b0;
      opt_run        <= 1'b0;
      exp_init       <= 1'b0;
      exp_run        <= 1'b0;
      exp_recip      <= '0;
      exp_fin        <= 1'b0;
      ex_run         <= 1'b0;
      distance_shift <= 1'b0;

      if (state != S_IDLE && stop) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        base_id <= '0;
        iter    <= '0;
        done    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (shift_req) begin
              state          <= S_SHIFT;
              busy           <= 1'b1;
              base_id        <= '0;
              distance_shift <= 1'b1;
            end else if (start) begin
              if (n_steps != 32'd0) begin
                state    <= S_OPT;
                busy     <= 1'b1;
                base_id  <= '0;
                opt_run  <= 1'b1;
                step_cnt <= '0;
                ex_odd   <= 1'b0;
                n_lat    <= n_steps;
              end else begin
                done <= 1'b1;
              end
            end
          end

          S_OPT: begin
            state    <= S_INIT;
            exp_init <= 1'b1;
          end

          S_INIT: begin
            state     <= S_EXP;
            iter      <= '0;
            exp_run   <= 1'b1;
            exp_recip <= recip_rom(K_TOP);
          end

          S_EXP: begin
            if (iter == ITER_LAST) begin
              state   <= S_FIN;
              iter    <= '0;
              exp_fin <= 1'b1;
            end else begin
              iter      <= iter + ITER_W'(1);
              exp_run   <= 1'b1;
              exp_recip <= recip_rom(K_TOP - iter - ITER_W'(1));
            end
          end

          S_FIN: begin
            state  <= S_EXCH;
            ex_run <= 1'b1;
          end

          S_EXCH: begin
            if (base_id != BASE_LAST) begin
              state   <= S_OPT;
              base_id <= base_id + BASE_LOG'(1);
              opt_run <= 1'b1;
            end else begin
              // sweep boundary: parity flips and the completed sweep is counted
              base_id  <= '0;
              step_cnt <= step_cnt + 32'd1;
              ex_odd   <= ~ex_odd;
              if (step_cnt + 32'd1 == n_lat) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= S_OPT;
                opt_run <= 1'b1;
              end
            end
          end

          S_SHIFT: begin
            if (base_id == BASE_LAST) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              base_id <= '0;
              done    <= 1'b1;
            end else begin
              base_id        <= base_id + BASE_LOG'(1);
              distance_shift <= 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_metropolis_sequencer.sv
// Bench for metropolis_sequencer: directed scenarios then random traffic, every cycle
// compared against a queue of expected output records built from the sweep/slot schedule.
module tb_metropolis_sequencer;

  localparam int unsigned BASE_NUM  = 4;
  localparam int unsigned BASE_LOG  = 2;
  localparam int unsigned EXP_ORDER = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [31:0]         n_steps;
  logic                shift_req;
  logic                stop;
  logic                busy;
  logic                done;
  logic [BASE_LOG-1:0] base_id;
  logic                opt_run;
  logic                exp_init;
  logic                exp_run;
  logic [16:0]         exp_recip;
  logic                exp_fin;
  logic                ex_run;
  logic                ex_odd;
  logic                distance_shift;
  logic [31:0]         step_cnt;

  metropolis_sequencer #(
    .BASE_NUM (BASE_NUM),
    .BASE_LOG (BASE_LOG),
    .EXP_ORDER(EXP_ORDER)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .n_steps       (n_steps),
    .shift_req     (shift_req),
    .stop          (stop),
    .busy          (busy),
    .done          (done),
    .base_id       (base_id),
    .opt_run       (opt_run),
    .exp_init      (exp_init),
    .exp_run       (exp_run),
    .exp_recip     (exp_recip),
    .exp_fin       (exp_fin),
    .ex_run        (ex_run),
    .ex_odd        (ex_odd),
    .distance_shift(distance_shift),
    .step_cnt      (step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [1:0]  base;
    logic        opt;
    logic        init;
    logic        er;
    logic [16:0] recip;
    logic        fin;
    logic        ex;
    logic        odd;
    logic        shift;
    logic [31:0] step;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, got, want);
    end
  endtask

  function automatic rec_t quiet(input rec_t prev);
    rec_t r;
    r      = '0;
    r.odd  = prev.odd;
    r.step = prev.step;
    return r;
  endfunction

  // Whole run laid out slot by slot: opt, init, EXP_ORDER iterations, fin, exchange
  task automatic push_run(input int n);
    rec_t r;
    int   k;
    for (int s = 0; s < n; s++) begin
      for (int b = 0; b < int'(BASE_NUM); b++) begin
        r      = '0;
        r.busy = 1'b1;
        r.base = 2'(b);
        r.odd  = 1'(s % 2);
        r.step = 32'(s);
        r.opt  = 1'b1; q.push_back(r); r.opt = 1'b0;
        r.init = 1'b1; q.push_back(r); r.init = 1'b0;
        for (int i = 0; i < int'(EXP_ORDER); i++) begin
          k       = int'(EXP_ORDER) - i;
          r.er    = 1'b1;
          r.recip = 17'((2 * 65536 + k) / (2 * k));
          q.push_back(r);
        end
        r.er    = 1'b0;
        r.recip = '0;
        r.fin   = 1'b1; q.push_back(r); r.fin = 1'b0;
        r.ex    = 1'b1; q.push_back(r);
      end
    end
    r      = '0;
    r.done = 1'b1;
    r.odd  = 1'(n % 2);
    r.step = 32'(n);
    q.push_back(r);
  endtask

  task automatic push_shift(input rec_t prev);
    rec_t r;
    for (int b = 0; b < int'(BASE_NUM); b++) begin
      r       = quiet(prev);
      r.busy  = 1'b1;
      r.shift = 1'b1;
      r.base  = 2'(b);
      q.push_back(r);
    end
    r      = quiet(prev);
    r.done = 1'b1;
    q.push_back(r);
  endtask

  // One clock: compare outputs against the current record, drive inputs, predict the next record
  task automatic tick(input logic st, input logic [31:0] n, input logic sr, input logic sp,
                      input logic rs);
    rec_t nxt;
    @(negedge clk);
    check("busy",      32'(busy),           32'(cur.busy));
    check("done",      32'(done),           32'(cur.done));
    check("base_id",   32'(base_id),        32'(cur.base));
    check("opt_run",   32'(opt_run),        32'(cur.opt));
    check("exp_init",  32'(exp_init),       32'(cur.init));
    check("exp_run",   32'(exp_run),        32'(cur.er));
    check("exp_recip", 32'(exp_recip),      32'(cur.recip));
    check("exp_fin",   32'(exp_fin),        32'(cur.fin));
    check("ex_run",    32'(ex_run),         32'(cur.ex));
    check("ex_odd",    32'(ex_odd),         32'(cur.odd));
    check("dist_shift",32'(distance_shift), 32'(cur.shift));
    check("step_cnt",  step_cnt,            cur.step);
    start     = st;
    n_steps   = n;
    shift_req = sr;
    stop      = sp;
    reset     = rs;
    if (rs) begin
      q.delete();
      nxt = '0;
    end else begin
      if (!cur.busy) begin
        if (sr) begin
          push_shift(cur);
        end else if (st) begin
          if (n == 32'd0) begin
            nxt      = quiet(cur);
            nxt.done = 1'b1;
            q.push_back(nxt);
          end else begin
            push_run(int'(n));
          end
        end
      end else if (sp) begin
        q.delete();
        nxt      = quiet(cur);
        nxt.done = 1'b1;
        q.push_back(nxt);
      end
      if (q.size() > 0) nxt = q.pop_front();
      else              nxt = quiet(cur);
    end
    cur = nxt;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    n_steps   = '0;
    shift_req = 1'b0;
    stop      = 1'b0;
    repeat (3) @(posedge clk);
    cur = '0;
    idle(10);

    // single sweep, then three sweeps with a start attempt mid-run
    tick(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    idle(52);
    tick(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    idle(60);
    tick(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    idle(90);

    // shift pass with a competing start
    tick(1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
    idle(8);

    // abort during exp of slot 2, then restart
    tick(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    idle(27);
    tick(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(3);
    tick(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    idle(52);

    // zero-length run and stop in idle
    tick(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // reset in the middle of a run
    tick(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    idle(30);
    tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(5);

    for (int c = 0; c < 4000; c++) begin
      tick(($urandom_range(0, 19) == 0),
           32'($urandom_range(0, 3)),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 999) == 0));
    end
    idle(160);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
